// File: rtl/bram_burst_engine.sv
// BRAM burst engine: read or pattern-write bursts on a native BRAM port,
// launched by a rising edge on start, with busy/done/aborted status back to the PS.
//
// Parameters:
//   DATA_W - word width (multiple of 8), ADDR_W - byte address width,
//   LEN_W  - word-count width, RD_LAT - BRAM read latency (1..4)
// Ports:
//   clk, rst_n (async, active-low)
//   start, mode, start_addr, len_words, wr_seed, wr_incr - launch controls
//   abort                      - stop the running burst after the current word
//   busy, done, aborted        - status
//   rd_valid, rd_data, rd_index - read word stream
//   ram_*                      - native BRAM port (Port B style)
module bram_burst_engine #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic [LEN_W-1:0]      len_words,
    input  logic [DATA_W-1:0]     wr_seed,
    input  logic [DATA_W-1:0]     wr_incr,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic [LEN_W-1:0]      rd_index,
    output logic                  ram_clk,
    output logic                  ram_rst,
    output logic                  ram_en,
    output logic [DATA_W/8-1:0]   ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wr_data,
    input  logic [DATA_W-1:0]     ram_rd_data
);

    localparam int BW = DATA_W / 8;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BW);
    localparam logic [2:0] DRAIN_LAST = 3'(RD_LAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t              state_q;
    logic                start_d0_q;
    logic                start_d1_q;
    logic                launch;
    logic                mode_q;
    logic [LEN_W-1:0]    len_q;
    logic [DATA_W-1:0]   incr_q;
    logic [LEN_W-1:0]    idx_q;
    logic [2:0]          dcnt_q;
    logic                busy_q;
    logic                done_q;
    logic                aborted_q;
    logic                en_q;
    logic [BW-1:0]       we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wd_q;
    logic                last_word;

    // Read-return delay line; the output register adds the final stage.
    logic [RD_LAT-1:0]   pv_q;
    logic [LEN_W-1:0]    pi_q [RD_LAT];
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic [LEN_W-1:0]    rd_index_q;

    assign launch    = start_d0_q & ~start_d1_q;
    assign last_word = (idx_q == len_q - LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_d0_q <= 1'b0;
            start_d1_q <= 1'b0;
        end else begin
            start_d0_q <= start;
            start_d1_q <= start_d0_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            len_q     <= '0;
            incr_q    <= '0;
            idx_q     <= '0;
            dcnt_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            en_q      <= 1'b0;
            we_q      <= '0;
            addr_q    <= '0;
            wd_q      <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        aborted_q <= 1'b0;
                        if (len_words != '0) begin
                            mode_q  <= mode;
                            len_q   <= len_words;
                            incr_q  <= wr_incr;
                            idx_q   <= '0;
                            en_q    <= 1'b1;
                            addr_q  <= start_addr;
                            we_q    <= mode ? '1 : '0;
                            wd_q    <= mode ? wr_seed : '0;
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end else begin
                            // Empty burst: report completion, touch nothing.
                            done_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (last_word || abort) begin
                        en_q    <= 1'b0;
                        we_q    <= '0;
                        addr_q  <= '0;
                        wd_q    <= '0;
                        dcnt_q  <= '0;
                        state_q <= S_DRAIN;
                        // Abort on the final word is a normal completion.
                        if (!last_word) begin
                            aborted_q <= 1'b1;
                        end
                    end else begin
                        idx_q  <= idx_q + LEN_W'(1);
                        addr_q <= addr_q + STEP;
                        if (mode_q) begin
                            wd_q <= wd_q + incr_q;
                        end
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        aborted_q <= 1'b1;
                    end
                    // RD_LAT+1 drain cycles let the last read word out first.
                    if (dcnt_q == DRAIN_LAST) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        dcnt_q <= dcnt_q + 3'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_index_q <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pi_q[k] <= '0;
            end
        end else begin
            pv_q[0] <= en_q & ~mode_q;
            pi_q[0] <= idx_q;
            for (int k = 1; k < RD_LAT; k++) begin
                pv_q[k] <= pv_q[k-1];
                pi_q[k] <= pi_q[k-1];
            end
            rd_valid_q <= pv_q[RD_LAT-1];
            if (pv_q[RD_LAT-1]) begin
                rd_data_q  <= ram_rd_data;
                rd_index_q <= pi_q[RD_LAT-1];
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign rd_index    = rd_index_q;
    assign ram_clk     = clk;
    assign ram_rst     = 1'b0;
    assign ram_en      = en_q;
    assign ram_we      = we_q;
    assign ram_addr    = addr_q;
    assign ram_wr_data = wd_q;

endmodule

// File: tb/tb_bram_burst_engine.sv
// Directed bench for bram_burst_engine with a RD_LAT=1 BRAM model.
// Covers read/write bursts, len=0, abort, start retrigger, wrap and reset.
module tb_bram_burst_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] start_addr = '0;
  logic [15:0] len_words = '0;
  logic [31:0] wr_seed = '0;
  logic [31:0] wr_incr = '0;
  logic        abort = 1'b0;
  logic        busy, done, aborted;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [15:0] rd_index;
  logic        ram_clk, ram_rst, ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_wr_data;
  logic [31:0] ram_rd_data;

  bram_burst_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .start_addr(start_addr), .len_words(len_words),
    .wr_seed(wr_seed), .wr_incr(wr_incr), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_index(rd_index),
    .ram_clk(ram_clk), .ram_rst(ram_rst), .ram_en(ram_en),
    .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [31:0] mem [1024];
  logic [31:0] rdq = '0;
  assign ram_rd_data = rdq;
  always @(posedge ram_clk) begin
    if (ram_en) begin
      if (ram_we != 4'h0) mem[ram_addr[11:2]] <= ram_wr_data;
      rdq <= mem[ram_addr[11:2]];
    end
  end

  int errs = 0;
  int chks = 0;

  task automatic check_eq(string tag, logic [63:0] got,
                          logic [63:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] q_addr [$];
  logic [31:0] q_wd [$];
  logic [3:0]  q_we [$];
  int          q_ecyc [$];
  logic [31:0] q_rd [$];
  logic [15:0] q_ri [$];
  int          q_rcyc [$];
  int          n_done = 0;
  int          done_cyc = 0;
  logic        ab_at_done = 1'b0;
  int          busy_seen = 0;
  int          busy_bad = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_en) begin
        q_addr.push_back(ram_addr);
        q_wd.push_back(ram_wr_data);
        q_we.push_back(ram_we);
        q_ecyc.push_back(cyc);
        if (!busy) busy_bad++;
      end
      if (rd_valid) begin
        q_rd.push_back(rd_data);
        q_ri.push_back(rd_index);
        q_rcyc.push_back(cyc);
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        ab_at_done = aborted;
      end
      if (busy) busy_seen++;
    end
  end

  task automatic clr();
    q_addr.delete(); q_wd.delete(); q_we.delete();
    q_ecyc.delete(); q_rd.delete(); q_ri.delete();
    q_rcyc.delete();
    n_done = 0; busy_seen = 0; busy_bad = 0;
  endtask

  task automatic launch(logic m, logic [31:0] a, logic [15:0] l,
                        logic [31:0] s, logic [31:0] inc);
    @(posedge clk); #1;
    mode = m; start_addr = a; len_words = l;
    wr_seed = s; wr_incr = inc; start = 1'b1;
  endtask

  task automatic wait_done(string tag, int maxc);
    int k;
    k = 0;
    while (n_done == 0 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_done_seen"}, 64'(n_done != 0), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) mem[16 + i] = 32'hA0 + 32'(i);

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_aborted", 64'(aborted), 64'd0);
    check_eq("rst_rd_valid", 64'(rd_valid), 64'd0);
    check_eq("rst_ram_en", 64'(ram_en), 64'd0);
    check_eq("rst_ram_we", 64'(ram_we), 64'd0);
    check_eq("rst_ram_addr", 64'(ram_addr), 64'd0);
    check_eq("rst_ram_rst", 64'(ram_rst), 64'd0);
    rst_n = 1'b1;

    // Read burst of four words from 0x40
    clr();
    launch(1'b0, 32'h40, 16'd4, 32'h0, 32'h0);
    wait_done("rd4", 40);
    check_eq("rd4_words", 64'(q_addr.size()), 64'd4);
    check_eq("rd4_valids", 64'(q_rd.size()), 64'd4);
    if (q_addr.size() == 4 && q_rd.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check_eq("rd4_addr", 64'(q_addr[i]), 64'(32'h40 + 4 * i));
        check_eq("rd4_we", 64'(q_we[i]), 64'd0);
        check_eq("rd4_idx", 64'(q_ri[i]), 64'(i));
        check_eq("rd4_data", 64'(q_rd[i]), 64'(32'hA0 + i));
        check_eq("rd4_lat", 64'(q_rcyc[i] - q_ecyc[i]), 64'd2);
      end
      check_eq("rd4_gapless", 64'(q_ecyc[3] - q_ecyc[0]), 64'd3);
      check_eq("rd4_done_lat", 64'(done_cyc - q_rcyc[3]), 64'd1);
    end
    check_eq("rd4_busy_cover", 64'(busy_bad), 64'd0);
    check_eq("rd4_aborted", 64'(ab_at_done), 64'd0);
    check_eq("rd4_busy_end", 64'(busy), 64'd0);

    // Pattern write of three words, then readback
    clr();
    launch(1'b1, 32'h100, 16'd3, 32'd5, 32'd2);
    wait_done("wr3", 40);
    check_eq("wr3_words", 64'(q_addr.size()), 64'd3);
    check_eq("wr3_no_rdvalid", 64'(q_rd.size()), 64'd0);
    if (q_addr.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check_eq("wr3_addr", 64'(q_addr[i]), 64'(32'h100 + 4 * i));
        check_eq("wr3_we", 64'(q_we[i]), 64'hF);
        check_eq("wr3_data", 64'(q_wd[i]), 64'(5 + 2 * i));
      end
    end
    clr();
    launch(1'b0, 32'h100, 16'd3, 32'h0, 32'h0);
    wait_done("rb3", 40);
    check_eq("rb3_valids", 64'(q_rd.size()), 64'd3);
    if (q_rd.size() == 3) begin
      for (int i = 0; i < 3; i++)
        check_eq("rb3_data", 64'(q_rd[i]), 64'(5 + 2 * i));
    end

    // Zero-length launch
    clr();
    launch(1'b0, 32'h40, 16'd0, 32'h0, 32'h0);
    wait_done("len0", 20);
    repeat (5) @(posedge clk);
    #1;
    check_eq("len0_done_cnt", 64'(n_done), 64'd1);
    check_eq("len0_ram_en", 64'(q_addr.size()), 64'd0);
    check_eq("len0_busy", 64'(busy_seen), 64'd0);

    // Abort after the third issued word
    clr();
    launch(1'b0, 32'h200, 16'd10, 32'h0, 32'h0);
    k = 0;
    while (q_addr.size() < 3 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("ab_third_word", 64'(q_addr.size() >= 3), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("ab", 40);
    check_eq("ab_words_3or4",
             64'(q_addr.size() == 3 || q_addr.size() == 4), 64'd1);
    check_eq("ab_all_valid", 64'(q_rd.size()), 64'(q_addr.size()));
    check_eq("ab_flag_done", 64'(ab_at_done), 64'd1);
    check_eq("ab_flag_held", 64'(aborted), 64'd1);
    check_eq("ab_done_cnt", 64'(n_done), 64'd1);

    // Retrigger during a 20-word burst; also clears aborted
    clr();
    launch(1'b0, 32'h40, 16'd20, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rt_aborted_clr", 64'(aborted), 64'd0);
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    wait_done("rt", 80);
    repeat (6) @(posedge clk);
    #1;
    check_eq("rt_words", 64'(q_addr.size()), 64'd20);
    check_eq("rt_valids", 64'(q_rd.size()), 64'd20);
    check_eq("rt_done_cnt", 64'(n_done), 64'd1);

    // Address wrap
    clr();
    launch(1'b0, 32'hFFFF_FFF8, 16'd4, 32'h0, 32'h0);
    wait_done("wrap", 40);
    check_eq("wrap_words", 64'(q_addr.size()), 64'd4);
    if (q_addr.size() == 4) begin
      check_eq("wrap_a0", 64'(q_addr[0]), 64'hFFFF_FFF8);
      check_eq("wrap_a1", 64'(q_addr[1]), 64'hFFFF_FFFC);
      check_eq("wrap_a2", 64'(q_addr[2]), 64'h0);
      check_eq("wrap_a3", 64'(q_addr[3]), 64'h4);
    end

    // Reset in the middle of a burst
    clr();
    launch(1'b0, 32'h300, 16'd10, 32'h0, 32'h0);
    k = 0;
    while (q_rd.size() < 1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("mr_active", 64'(ram_en & busy & rd_valid), 64'd1);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("mr_ram_en", 64'(ram_en), 64'd0);
    check_eq("mr_busy", 64'(busy), 64'd0);
    check_eq("mr_rd_valid", 64'(rd_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clr();
    launch(1'b0, 32'h40, 16'd4, 32'h0, 32'h0);
    wait_done("pr", 40);
    check_eq("pr_words", 64'(q_addr.size()), 64'd4);
    check_eq("pr_valids", 64'(q_rd.size()), 64'd4);
    if (q_rd.size() == 4) begin
      for (int i = 0; i < 4; i++)
        check_eq("pr_data", 64'(q_rd[i]), 64'(32'hA0 + i));
    end

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
